// File: rtl/imm_encoder.sv
// imm_encoder: packs a signed immediate into the I/S/B/J fields of an instruction template.
// Two-stage valid/ready pipeline: stage 1 range-checks the immediate, stage 2 packs it and drives the outputs.
module imm_encoder #(
  parameter int unsigned CNT_W    = 16,
  parameter bit          CHECK_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [31:0]      in_imm_i,
  input  logic [1:0]       in_ImmSrc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_instr_o,
  output logic             out_err_o,
  output logic [CNT_W-1:0] err_count_o
);

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } fmt_e;

  // An immediate fits when every bit above the field's sign bit equals that sign bit.
  function automatic logic rangeErr(input logic [31:0] imm, input fmt_e fmt);
    logic bad;
    bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: bad = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] packImm(input logic [31:0] instr, input logic [20:0] imm,
                                          input fmt_e fmt);
    logic [31:0] p;
    p = instr;
    case (fmt)
      FMT_I: p[31:20] = imm[11:0];
      FMT_S: begin
        p[31:25] = imm[11:5];
        p[11:7]  = imm[4:0];
      end
      FMT_B: begin
        p[31]    = imm[12];
        p[7]     = imm[11];
        p[30:25] = imm[10:5];
        p[11:8]  = imm[4:1];
      end
      FMT_J: begin
        p[31]    = imm[20];
        p[19:12] = imm[19:12];
        p[20]    = imm[11];
        p[30:21] = imm[10:1];
      end
      default: p = instr;
    endcase
    return p;
  endfunction

  logic             stall;
  logic             inErr;

  logic             s1Valid_q, s1Valid_d;
  logic [31:0]      s1Instr_q, s1Instr_d;
  logic [20:0]      s1Imm_q, s1Imm_d;
  fmt_e             s1Fmt_q, s1Fmt_d;
  logic             s1Err_q, s1Err_d;

  logic             outValid_q, outValid_d;
  logic [31:0]      outInstr_q, outInstr_d;
  logic             outErr_q, outErr_d;
  logic [CNT_W-1:0] errCount_q, errCount_d;

  assign stall      = outValid_q & ~out_ready_i;
  assign in_ready_o = ~stall | ~s1Valid_q;
  assign inErr      = CHECK_EN ? rangeErr(in_imm_i, fmt_e'(in_ImmSrc_i)) : 1'b0;

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Instr_d  = s1Instr_q;
    s1Imm_d    = s1Imm_q;
    s1Fmt_d    = s1Fmt_q;
    s1Err_d    = s1Err_q;
    outValid_d = outValid_q;
    outInstr_d = outInstr_q;
    outErr_d   = outErr_q;
    errCount_d = errCount_q;

    // Stage 1 refills whenever it is empty or its beat moves on this cycle.
    if (in_ready_o) begin
      s1Valid_d = in_valid_i;
      if (in_valid_i) begin
        s1Instr_d = in_instr_i;
        s1Imm_d   = in_imm_i[20:0];
        s1Fmt_d   = fmt_e'(in_ImmSrc_i);
        s1Err_d   = inErr;
      end
    end

    if (!stall) begin
      outValid_d = s1Valid_q;
      if (s1Valid_q) begin
        outInstr_d = s1Err_q ? s1Instr_q : packImm(s1Instr_q, s1Imm_q, s1Fmt_q);
        outErr_d   = s1Err_q;
      end
    end

    if (outValid_q && out_ready_i && outErr_q && (errCount_q != '1)) begin
      errCount_d = errCount_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1Valid_q  <= 1'b0;
      s1Instr_q  <= '0;
      s1Imm_q    <= '0;
      s1Fmt_q    <= FMT_I;
      s1Err_q    <= 1'b0;
      outValid_q <= 1'b0;
      outInstr_q <= '0;
      outErr_q   <= 1'b0;
      errCount_q <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Instr_q  <= s1Instr_d;
      s1Imm_q    <= s1Imm_d;
      s1Fmt_q    <= s1Fmt_d;
      s1Err_q    <= s1Err_d;
      outValid_q <= outValid_d;
      outInstr_q <= outInstr_d;
      outErr_q   <= outErr_d;
      errCount_q <= errCount_d;
    end
  end

  assign out_valid_o = outValid_q;
  assign out_instr_o = outInstr_q;
  assign out_err_o   = outErr_q;
  assign err_count_o = errCount_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder: checks the field vectors, the range edges, backpressure, reset and counter saturation.
// Three instances share the stimulus: default, a 2-bit error counter, and range checks disabled.
module tb_imm_encoder;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic [31:0] inInstr;
  logic [31:0] inImm;
  logic [1:0]  inSrc;
  logic        outReady;

  logic        inReady, outValid, outErr;
  logic [31:0] outInstr;
  logic [15:0] errCount;

  logic        satInReady, satOutValid, satOutErr;
  logic [31:0] satOutInstr;
  logic [1:0]  satErrCount;

  logic        ncInReady, ncOutValid, ncOutErr;
  logic [31:0] ncOutInstr;
  logic [15:0] ncErrCount;

  int testCount = 0;
  int failCount = 0;
  int expErrCnt = 0;

  imm_encoder dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(inValid), .in_ready_o(inReady),
    .in_instr_i(inInstr), .in_imm_i(inImm), .in_ImmSrc_i(inSrc),
    .out_valid_o(outValid), .out_ready_i(outReady), .out_instr_o(outInstr),
    .out_err_o(outErr), .err_count_o(errCount)
  );

  imm_encoder #(.CNT_W(2)) dutSat (
    .clk_i(clk), .reset_i(reset), .in_valid_i(inValid), .in_ready_o(satInReady),
    .in_instr_i(inInstr), .in_imm_i(inImm), .in_ImmSrc_i(inSrc),
    .out_valid_o(satOutValid), .out_ready_i(outReady), .out_instr_o(satOutInstr),
    .out_err_o(satOutErr), .err_count_o(satErrCount)
  );

  imm_encoder #(.CHECK_EN(1'b0)) dutNoChk (
    .clk_i(clk), .reset_i(reset), .in_valid_i(inValid), .in_ready_o(ncInReady),
    .in_instr_i(inInstr), .in_imm_i(inImm), .in_ImmSrc_i(inSrc),
    .out_valid_o(ncOutValid), .out_ready_i(outReady), .out_instr_o(ncOutInstr),
    .out_err_o(ncOutErr), .err_count_o(ncErrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backpressure stream: template, immediate, format, packed result, error flag.
  localparam logic [31:0] BP_INSTR [8] = '{32'h13, 32'h2023, 32'h63, 32'h63,
                                           32'h6F, 32'h6F, 32'hFFFFFFFF, 32'h63};
  localparam logic [31:0] BP_IMM   [8] = '{32'hFFFFFFFF, 32'h7E5, 32'hFFFFF000, 32'h3,
                                           32'hFFFFE, 32'h100000, 32'h0, 32'hFFE};
  localparam logic [1:0]  BP_SRC   [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2};
  localparam logic [31:0] BP_EXP   [8] = '{32'hFFF00013, 32'h7E0022A3, 32'h80000063, 32'h63,
                                           32'h7FFFF06F, 32'h6F, 32'h000FFFFF, 32'h7E000FE3};
  localparam logic        BP_ERR   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [15:0] READY_PAT = 16'b0110_1001_1100_0101;

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] imm,
                               input logic [1:0] src);
    inValid = v;
    inInstr = instr;
    inImm   = imm;
    inSrc   = src;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat through an idle pipeline with the output always ready: it appears after the second edge.
  task automatic sendBeat(input string tag, input logic [31:0] instr, input logic [31:0] imm,
                          input logic [1:0] src, input logic [31:0] expInstr, input logic expErr,
                          input logic [31:0] expNoChk);
    applyStimulus(1'b1, instr, imm, src);
    step();
    applyStimulus(1'b0, instr, imm, src);
    checkOutput({tag, " early"}, {31'd0, outValid}, 32'd0);
    step();
    checkOutput({tag, " valid"}, {31'd0, outValid}, 32'd1);
    checkOutput({tag, " instr"}, outInstr, expInstr);
    checkOutput({tag, " err"}, {31'd0, outErr}, {31'd0, expErr});
    checkOutput({tag, " nochk instr"}, ncOutInstr, expNoChk);
    checkOutput({tag, " nochk err"}, {31'd0, ncOutErr}, 32'd0);
    if (expErr) expErrCnt++;
  endtask

  initial begin
    int nSent, nRecv;
    logic holdPending, holdErr, accIn, accOut;
    logic [31:0] holdInstr;

    reset    = 1'b1;
    outReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0);
    step();
    step();
    checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("reset out_instr", outInstr, 32'd0);
    checkOutput("reset out_err", {31'd0, outErr}, 32'd0);
    checkOutput("reset err_count", {16'd0, errCount}, 32'd0);
    reset = 1'b0;
    step();
    checkOutput("post-reset in_ready", {31'd0, inReady}, 32'd1);

    // Directed format vectors and range edges.
    sendBeat("I -1", 32'h13, 32'hFFFFFFFF, 2'd0, 32'hFFF00013, 1'b0, 32'hFFF00013);
    sendBeat("S 0x7E5", 32'h2023, 32'h7E5, 2'd1, 32'h7E0022A3, 1'b0, 32'h7E0022A3);
    sendBeat("B -4096", 32'h63, 32'hFFFFF000, 2'd2, 32'h80000063, 1'b0, 32'h80000063);
    sendBeat("B odd", 32'h63, 32'h3, 2'd2, 32'h63, 1'b1, 32'h163);
    sendBeat("J max", 32'h6F, 32'hFFFFE, 2'd3, 32'h7FFFF06F, 1'b0, 32'h7FFFF06F);
    sendBeat("J over", 32'h6F, 32'h100000, 2'd3, 32'h6F, 1'b1, 32'h8000006F);
    sendBeat("I 2047", 32'h13, 32'h7FF, 2'd0, 32'h7FF00013, 1'b0, 32'h7FF00013);
    sendBeat("I 2048", 32'h13, 32'h800, 2'd0, 32'h13, 1'b1, 32'h80000013);
    sendBeat("I -2048", 32'h13, 32'hFFFFF800, 2'd0, 32'h80000013, 1'b0, 32'h80000013);
    sendBeat("S -2048", 32'h2023, 32'hFFFFF800, 2'd1, 32'h80002023, 1'b0, 32'h80002023);
    sendBeat("B 4094", 32'h63, 32'hFFE, 2'd2, 32'h7E000FE3, 1'b0, 32'h7E000FE3);
    sendBeat("B 4096", 32'h63, 32'h1000, 2'd2, 32'h63, 1'b1, 32'h80000063);
    sendBeat("J min", 32'h6F, 32'hFFF00000, 2'd3, 32'h8000006F, 1'b0, 32'h8000006F);
    sendBeat("I keep", 32'hFFFFFFFF, 32'h0, 2'd0, 32'h000FFFFF, 1'b0, 32'h000FFFFF);
    step();
    checkOutput("drain out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("err_count directed", {16'd0, errCount}, expErrCnt);
    checkOutput("sat err_count", {30'd0, satErrCount}, 32'd3);
    checkOutput("nochk err_count", {16'd0, ncErrCount}, 32'd0);

    // Backpressure stream against a fixed ready pattern.
    nSent = 0;
    nRecv = 0;
    holdPending = 1'b0;
    holdErr = 1'b0;
    holdInstr = 32'h0;
    for (int cyc = 0; cyc < 200 && nRecv < 8; cyc++) begin
      outReady = READY_PAT[cyc % 16];
      if (nSent < 8) applyStimulus(1'b1, BP_INSTR[nSent], BP_IMM[nSent], BP_SRC[nSent]);
      else applyStimulus(1'b0, 32'h0, 32'h0, 2'd0);
      #1;
      if (holdPending) begin
        checkOutput("bp hold valid", {31'd0, outValid}, 32'd1);
        checkOutput("bp hold instr", outInstr, holdInstr);
        checkOutput("bp hold err", {31'd0, outErr}, {31'd0, holdErr});
      end
      accIn  = inValid && inReady;
      accOut = outValid && outReady;
      if (accOut) begin
        checkOutput("bp instr", outInstr, BP_EXP[nRecv]);
        checkOutput("bp err", {31'd0, outErr}, {31'd0, BP_ERR[nRecv]});
        if (BP_ERR[nRecv]) expErrCnt++;
        nRecv++;
      end
      holdPending = outValid && !outReady;
      holdInstr   = outInstr;
      holdErr     = outErr;
      if (accIn) nSent++;
      step();
    end
    checkOutput("bp beats received", nRecv, 32'd8);
    outReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0);
    checkOutput("bp no duplicate", {31'd0, outValid}, 32'd0);
    checkOutput("bp err_count", {16'd0, errCount}, expErrCnt);

    // Reset with two beats in flight, then a fresh beat.
    outReady = 1'b0;
    applyStimulus(1'b1, 32'h63, 32'h3, 2'd2);
    step();
    applyStimulus(1'b1, 32'h13, 32'h5, 2'd0);
    step();
    checkOutput("stalled in_ready", {31'd0, inReady}, 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0);
    reset = 1'b1;
    step();
    checkOutput("midreset out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("midreset err_count", {16'd0, errCount}, 32'd0);
    checkOutput("midreset sat count", {30'd0, satErrCount}, 32'd0);
    reset = 1'b0;
    outReady = 1'b1;
    expErrCnt = 0;
    step();
    checkOutput("after reset in_ready", {31'd0, inReady}, 32'd1);
    sendBeat("post S", 32'h2023, 32'h7E5, 2'd1, 32'h7E0022A3, 1'b0, 32'h7E0022A3);
    step();
    checkOutput("no ghost beat", {31'd0, outValid}, 32'd0);

    // Saturation of the 2-bit counter.
    sendBeat("sat 1", 32'h63, 32'h3, 2'd2, 32'h63, 1'b1, 32'h163);
    sendBeat("sat 2", 32'h6F, 32'h100000, 2'd3, 32'h6F, 1'b1, 32'h8000006F);
    sendBeat("sat 3", 32'h13, 32'h800, 2'd0, 32'h13, 1'b1, 32'h80000013);
    sendBeat("sat 4", 32'h63, 32'h1000, 2'd2, 32'h63, 1'b1, 32'h80000063);
    step();
    checkOutput("final err_count", {16'd0, errCount}, expErrCnt);
    checkOutput("final sat count", {30'd0, satErrCount}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
